mul_pipeline: RTL and testbench

- Fixed five-stage pipelined integer multiply unit. Receives multiply ops from decode/issue and writes results back to the register file.
- Produces the per-stage destination address and valid flags (m1..m5 reg_dest_addr / is_mul) that the hazard detection unit uses to stall dependent instructions.
- The pipeline advances independently of the main ALU path; it freezes only when the writeback port is blocked.

---
 rtl/mul_pipeline.sv | 101 ++++++++++
 tb/tb_mul_pipeline.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_pipeline.sv
// mul_pipeline: five-stage pipelined integer multiplier with per-stage hazard tags for the stall unit.
// Define MUL_HIGH_EN to add issue_op_in and the MULH/MULHSU/MULHU high-half results.
module mul_pipeline #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid_in,
    output logic                  issue_ready_out,
    input  logic [REG_ADDR_W-1:0] issue_rd_in,
    input  logic [XLEN-1:0]       issue_a_in,
    input  logic [XLEN-1:0]       issue_b_in,
    input  logic                  issue_kill_in,
`ifdef MUL_HIGH_EN
    input  logic [1:0]            issue_op_in,
`endif
    input  logic                  wb_stall_in,
    output logic [REG_ADDR_W-1:0] m1_reg_dest_addr_out,
    output logic [REG_ADDR_W-1:0] m2_reg_dest_addr_out,
    output logic [REG_ADDR_W-1:0] m3_reg_dest_addr_out,
    output logic [REG_ADDR_W-1:0] m4_reg_dest_addr_out,
    output logic [REG_ADDR_W-1:0] m5_reg_dest_addr_out,
    output logic                  m1_is_mul_out,
    output logic                  m2_is_mul_out,
    output logic                  m3_is_mul_out,
    output logic                  m4_is_mul_out,
    output logic                  m5_is_mul_out,
    output logic                  wb_valid_out,
    output logic [REG_ADDR_W-1:0] wb_rd_out,
    output logic [XLEN-1:0]       wb_data_out
);
`ifdef MUL_HIGH_EN
    localparam int PW = 2*XLEN+2;
`else
    localparam int PW = XLEN;
`endif
    logic                       w_advance;
    logic [PW-1:0]              w_prod;
    logic [5:1]                 r_vld;
    logic [5:1][REG_ADDR_W-1:0] r_rd;
    logic [XLEN-1:0]            r_a;
    logic [XLEN-1:0]            r_b;
    logic [5:2][PW-1:0]         r_prod;

    assign w_advance       = ~wb_stall_in;
    assign issue_ready_out = w_advance;

`ifdef MUL_HIGH_EN
    logic [5:1][1:0] r_op;
    logic            w_a_sx;
    logic            w_b_sx;

    // Extending straight to the full product width gives the same bits as a signed (XLEN+1)x(XLEN+1) multiply.
    assign w_a_sx      = (r_op[1] == 2'b01 || r_op[1] == 2'b10) & r_a[XLEN-1];
    assign w_b_sx      = (r_op[1] == 2'b01) & r_b[XLEN-1];
    assign w_prod      = {{(XLEN+2){w_a_sx}}, r_a} * {{(XLEN+2){w_b_sx}}, r_b};
    assign wb_data_out = (r_op[5] == 2'b00) ? r_prod[5][XLEN-1:0] : r_prod[5][2*XLEN-1:XLEN];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op <= '0;
        end else if (w_advance) begin
            r_op <= {r_op[4:1], issue_op_in};
        end
    end
`else
    assign w_prod      = r_a * r_b;
    assign wb_data_out = r_prod[5];
`endif

    // Kill drops the m1 entry on its way to m2; x0 destinations enter m1 as bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld  <= '0;
            r_rd   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_prod <= '0;
        end else if (w_advance) begin
            r_vld  <= {r_vld[4:2], r_vld[1] & ~issue_kill_in, issue_valid_in & (issue_rd_in != '0)};
            r_rd   <= {r_rd[4:1], issue_rd_in};
            r_a    <= issue_a_in;
            r_b    <= issue_b_in;
            r_prod <= {r_prod[4:2], w_prod};
        end
    end

    assign m1_reg_dest_addr_out = r_rd[1];
    assign m2_reg_dest_addr_out = r_rd[2];
    assign m3_reg_dest_addr_out = r_rd[3];
    assign m4_reg_dest_addr_out = r_rd[4];
    assign m5_reg_dest_addr_out = r_rd[5];
    assign m1_is_mul_out        = r_vld[1];
    assign m2_is_mul_out        = r_vld[2];
    assign m3_is_mul_out        = r_vld[3];
    assign m4_is_mul_out        = r_vld[4];
    assign m5_is_mul_out        = r_vld[5];
    assign wb_valid_out         = r_vld[5];
    assign wb_rd_out            = r_rd[5];
endmodule

// File: tb/tb_mul_pipeline.sv
// tb_mul_pipeline: directed table, corner sequences and random traffic against an age-list reference model.
module tb_mul_pipeline;
    logic        clk;
    logic        reset;
    logic        issue_valid_in;
    logic        issue_ready_out;
    logic [4:0]  issue_rd_in;
    logic [31:0] issue_a_in;
    logic [31:0] issue_b_in;
    logic        issue_kill_in;
    logic [1:0]  issue_op_in;
    logic        wb_stall_in;
    wire  [5:1]  m_is;
    wire  [4:0]  m_rd [1:5];
    logic        wb_valid_out;
    logic [4:0]  wb_rd_out;
    logic [31:0] wb_data_out;

    mul_pipeline dut (
        .clk                 (clk),
        .reset               (reset),
        .issue_valid_in      (issue_valid_in),
        .issue_ready_out     (issue_ready_out),
        .issue_rd_in         (issue_rd_in),
        .issue_a_in          (issue_a_in),
        .issue_b_in          (issue_b_in),
        .issue_kill_in       (issue_kill_in),
`ifdef MUL_HIGH_EN
        .issue_op_in         (issue_op_in),
`endif
        .wb_stall_in         (wb_stall_in),
        .m1_reg_dest_addr_out(m_rd[1]),
        .m2_reg_dest_addr_out(m_rd[2]),
        .m3_reg_dest_addr_out(m_rd[3]),
        .m4_reg_dest_addr_out(m_rd[4]),
        .m5_reg_dest_addr_out(m_rd[5]),
        .m1_is_mul_out       (m_is[1]),
        .m2_is_mul_out       (m_is[2]),
        .m3_is_mul_out       (m_is[3]),
        .m4_is_mul_out       (m_is[4]),
        .m5_is_mul_out       (m_is[5]),
        .wb_valid_out        (wb_valid_out),
        .wb_rd_out           (wb_rd_out),
        .wb_data_out         (wb_data_out)
    );

    typedef struct {logic [4:0] rd; logic [31:0] a; logic [31:0] b; logic [1:0] op; int age;} op_t;
    typedef struct {logic [4:0] rd; logic [31:0] data; int edge_n;} wb_t;
    typedef struct {logic [4:0] rd; logic [31:0] a; logic [31:0] b; logic [1:0] op; logic [31:0] exp;} vec_t;

    op_t  q[$];
    wb_t  wlog[$];
    vec_t tab[$];
    int   checks = 0;
    int   errors = 0;
    int   ncyc = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ncyc);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        logic [63:0] p;
        case (op)
            2'd1:    p = longint'($signed(a)) * longint'($signed(b));
            2'd2:    p = longint'($signed(a)) * longint'({32'b0, b});
            default: p = {32'b0, a} * {32'b0, b};
        endcase
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Each live op ages by one per advancing edge; age k means it sits in stage k.
    function automatic void model_edge(input logic v, input logic [4:0] rd, input logic [31:0] a,
                                       input logic [31:0] b, input logic [1:0] op, input logic kill,
                                       input logic stall);
        op_t nq[$];
        op_t t;
        if (stall) return;
        foreach (q[i]) begin
            if (q[i].age == 5 || (q[i].age == 1 && kill)) continue;
            t = q[i];
            t.age++;
            nq.push_back(t);
        end
        if (v && rd != 0) nq.push_back('{rd, a, b, op, 1});
        q = nq;
    endfunction

    function automatic int find_age(input int k);
        foreach (q[i]) if (q[i].age == k) return i;
        return -1;
    endfunction

    task automatic compare_all();
        int idx;
        for (int k = 1; k <= 5; k++) begin
            idx = find_age(k);
            chk($sformatf("m%0d_is_mul", k), m_is[k], idx >= 0);
            if (idx >= 0) chk($sformatf("m%0d_rd", k), m_rd[k], q[idx].rd);
        end
        idx = find_age(5);
        chk("wb_valid", wb_valid_out, idx >= 0);
        if (idx >= 0) begin
            chk("wb_rd", wb_rd_out, q[idx].rd);
            chk("wb_data", wb_data_out, ref_mul(q[idx].a, q[idx].b, q[idx].op));
        end
    endtask

    task automatic cycle(input logic v, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic kill, input logic stall);
        issue_valid_in = v;
        issue_rd_in    = rd;
        issue_a_in     = a;
        issue_b_in     = b;
        issue_op_in    = op;
        issue_kill_in  = kill;
        wb_stall_in    = stall;
        #1;
        chk("issue_ready", issue_ready_out, !stall);
        if (wb_valid_out && !stall) wlog.push_back('{wb_rd_out, wb_data_out, ncyc + 1});
        model_edge(v, rd, a, b, op, kill, stall);
        @(posedge clk);
        ncyc++;
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int count_rd(input logic [4:0] rd);
        int n = 0;
        foreach (wlog[i]) if (wlog[i].rd == rd) n++;
        return n;
    endfunction

    initial begin
        int acc;
        logic [1:0] rop;
        reset = 0;
        issue_valid_in = 0; issue_rd_in = 0; issue_a_in = 0; issue_b_in = 0;
        issue_op_in = 0; issue_kill_in = 0; wb_stall_in = 0;
        #2;
        for (int k = 1; k <= 5; k++) begin
            chk("rst_is_mul", m_is[k], 0);
            chk("rst_rd", m_rd[k], 0);
        end
        chk("rst_wb_valid", wb_valid_out, 0);
        chk("rst_wb_rd", wb_rd_out, 0);
        chk("rst_wb_data", wb_data_out, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1;

        // Single op walks m1..m5 and writes back five edges after accept.
        cycle(1, 5, 7, 6, 0, 0, 0);
        acc = ncyc;
        chk("single_m1_rd", m_rd[1], 5);
        for (int k = 2; k <= 5; k++) begin
            idle(1);
            chk($sformatf("single_m%0d_rd", k), m_rd[k], 5);
            chk($sformatf("single_m%0d_is", k), m_is[k], 1);
        end
        chk("single_wb_valid", wb_valid_out, 1);
        chk("single_wb_rd", wb_rd_out, 5);
        chk("single_wb_data", wb_data_out, 42);
        idle(1);
        chk("single_count", wlog.size(), 1);
        if (wlog.size() == 1) chk("single_latency", wlog[0].edge_n - acc, 5);
        wlog.delete();

        // Directed table issued back to back.
        for (int i = 1; i <= 5; i++) tab.push_back('{5'(i), 32'hFFFFFFFF, 32'd2, 2'd0, 32'hFFFFFFFE});
        tab.push_back('{5'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0, 32'd1});
        tab.push_back('{5'd7, 32'h00010000, 32'h00010000, 2'd0, 32'd0});
        tab.push_back('{5'd8, 32'h80000000, 32'd2, 2'd0, 32'd0});
        tab.push_back('{5'd11, 32'd12345, 32'd678, 2'd0, 32'd8369910});
        tab.push_back('{5'd12, 32'd0, 32'hDEADBEEF, 2'd0, 32'd0});
`ifdef MUL_HIGH_EN
        tab.push_back('{5'd13, 32'h80000000, 32'd2, 2'd1, 32'hFFFFFFFF});
        tab.push_back('{5'd14, 32'h80000000, 32'd2, 2'd3, 32'h00000001});
        tab.push_back('{5'd15, 32'hFFFFFFFF, 32'd2, 2'd2, 32'hFFFFFFFF});
        tab.push_back('{5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd1, 32'h00000000});
`endif
        foreach (tab[i]) cycle(1, tab[i].rd, tab[i].a, tab[i].b, tab[i].op, 0, 0);
        idle(6);
        chk("tab_count", wlog.size(), tab.size());
        foreach (tab[i]) if (i < wlog.size()) begin
            chk($sformatf("tab%0d_rd", i), wlog[i].rd, tab[i].rd);
            chk($sformatf("tab%0d_data", i), wlog[i].data, tab[i].exp);
            chk($sformatf("tab%0d_edge", i), wlog[i].edge_n - wlog[0].edge_n, i);
        end
        wlog.delete();

        // Stall for three cycles while m5 is valid; new issues are ignored meanwhile.
        cycle(1, 3, 100, 200, 0, 0, 0);
        acc = ncyc;
        idle(4);
        chk("stall_wb_valid", wb_valid_out, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 7, 1, 1, 0, 0, 1);
            chk("stall_hold_valid", wb_valid_out, 1);
            chk("stall_hold_data", wb_data_out, 20000);
            chk("stall_hold_m1", m_is[1], 0);
        end
        idle(1);
        chk("stall_count", wlog.size(), 1);
        if (wlog.size() == 1) begin
            chk("stall_latency", wlog[0].edge_n - acc, 8);
            chk("stall_data", wlog[0].data, 20000);
        end
        idle(5);
        chk("stall_no_ignored", count_rd(7), 0);
        wlog.delete();

        // Kill alone, kill with a same-cycle accept, and x0 destination.
        cycle(1, 9, 3, 3, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        chk("kill_m2", m_is[2], 0);
        cycle(1, 9, 4, 4, 0, 0, 0);
        cycle(1, 10, 5, 5, 0, 1, 0);
        chk("killacc_m1", m_is[1], 1);
        chk("killacc_m2", m_is[2], 0);
        cycle(1, 0, 6, 6, 0, 0, 0);
        chk("x0_m1", m_is[1], 0);
        idle(7);
        chk("kill_no_rd9", count_rd(9), 0);
        chk("kill_rd10", count_rd(10), 1);
        chk("x0_no_wb", count_rd(0), 0);
        wlog.delete();

        // Asynchronous reset with three ops in flight.
        cycle(1, 20, 1, 2, 0, 0, 0);
        cycle(1, 21, 3, 4, 0, 0, 0);
        cycle(1, 22, 5, 6, 0, 0, 0);
        reset = 0;
        #1;
        for (int k = 1; k <= 5; k++) chk($sformatf("arst_m%0d_is", k), m_is[k], 0);
        chk("arst_wb_valid", wb_valid_out, 0);
        q.delete();
        @(posedge clk);
        ncyc++;
        #1;
        reset = 1;
        wlog.delete();
        idle(8);
        chk("arst_no_wb", wlog.size(), 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
`ifdef MUL_HIGH_EN
            rop = 2'($urandom_range(0, 3));
`else
            rop = 2'd0;
`endif
            cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom,
                  ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom,
                  rop, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
